// File: rtl/axil_reg_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register bank.
package axil_reg_pkg;

  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned RESP_SLVERR = 2;

  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_DATA  = 4'h4;
  localparam logic [3:0] OFF_ACC   = 4'h8;
  localparam logic [3:0] OFF_COUNT = 4'hC;

  typedef enum logic [0:0] {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the register bank.
interface axil_reg_slave_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_decode.sv
// Combinational address decode for the four-word register bank.
module axil_reg_decode
  import axil_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [1:0]            idx_o,
  output logic                  writable_o
);
  logic [ADDR_WIDTH-1:0] off;

  always_comb begin
    off        = addr_i - ADDR_WIDTH'(BASE_ADDR);
    hit_o      = (off[ADDR_WIDTH-1:4] == '0) && (off[1:0] == 2'b00) && (addr_i[1:0] == 2'b00);
    idx_o      = off[3:2];
    writable_o = hit_o && ((off[3:0] == OFF_CTRL) || (off[3:0] == OFF_DATA));
  end
endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: CTRL/DATA (RW), ACC/COUNT (RO).
// Define AXIL_REG_SLAVE_WSTRB_EN to honour wstrb byte lanes on CTRL/DATA writes.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  axil_reg_slave_if.slave       s_axi,
  output logic [DATA_WIDTH-1:0] ctrl_out,
  output logic [DATA_WIDTH-1:0] acc_out
);
  localparam logic [RESP_WIDTH-1:0] RespOkay  = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] RespSlverr = RESP_WIDTH'(RESP_SLVERR);

  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d, data_q, data_d, acc_q, acc_d, count_q, count_d;
  wr_state_t             wr_state_q, wr_state_d;
  rd_state_t             rd_state_q, rd_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                  aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, ctrl_merge, data_merge, rd_reg;
  logic                  wr_hit, wr_writable, rd_hit, rd_writable;
  logic [1:0]            wr_idx, rd_idx;

  // A write may complete with one half already held and the other arriving live.
  assign wr_addr = aw_have_q ? awaddr_q : s_axi.awaddr;
  assign wr_data = w_have_q ? wdata_q : s_axi.wdata;

`ifdef AXIL_REG_SLAVE_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d, wr_strb;
  assign wr_strb = w_have_q ? wstrb_q : s_axi.wstrb;

  always_comb begin
    ctrl_merge = ctrl_q;
    data_merge = data_q;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (wr_strb[i]) begin
        ctrl_merge[i*8+:8] = wr_data[i*8+:8];
        data_merge[i*8+:8] = wr_data[i*8+:8];
      end
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^s_axi.wstrb;
  assign ctrl_merge   = wr_data;
  assign data_merge   = wr_data;
`endif

  axil_reg_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR)) u_aw_decode (
    .addr_i     (wr_addr),
    .hit_o      (wr_hit),
    .idx_o      (wr_idx),
    .writable_o (wr_writable)
  );

  axil_reg_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR)) u_ar_decode (
    .addr_i     (s_axi.araddr),
    .hit_o      (rd_hit),
    .idx_o      (rd_idx),
    .writable_o (rd_writable)
  );

  assign aw_hs = s_axi.awvalid & awready_q;
  assign w_hs  = s_axi.wvalid & wready_q;
  assign ar_hs = s_axi.arvalid & arready_q;

  always_comb begin
    ctrl_d     = ctrl_q;
    data_d     = data_q;
    acc_d      = acc_q;
    count_d    = count_q;
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    aw_have_d  = aw_have_q;
    w_have_d   = w_have_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
`ifdef AXIL_REG_SLAVE_WSTRB_EN
    wstrb_d    = wstrb_q;
    if (w_hs) wstrb_d = s_axi.wstrb;
`endif
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (w_hs) begin
          w_have_d = 1'b1;
          wdata_d  = s_axi.wdata;
        end
        awready_d = ~(aw_have_q | aw_hs);
        wready_d  = ~(w_have_q | w_hs);
        if ((aw_have_q | aw_hs) && (w_have_q | w_hs)) begin
          wr_state_d = W_RESP;
          bvalid_d   = 1'b1;
          aw_have_d  = 1'b0;
          w_have_d   = 1'b0;
          bresp_d    = RespSlverr;
          if (wr_writable) begin
            bresp_d = RespOkay;
            count_d = count_q + DATA_WIDTH'(1);
            if (wr_idx == OFF_CTRL[3:2]) begin
              // Bit 1 is a clear strobe for ACC and never stays set.
              ctrl_d    = ctrl_merge;
              ctrl_d[1] = 1'b0;
              if (ctrl_merge[1]) acc_d = '0;
            end else begin
              data_d = data_merge;
              if (ctrl_q[0]) acc_d = acc_q + data_merge;
            end
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    unique case (rd_idx)
      OFF_CTRL[3:2]: rd_reg = ctrl_q;
      OFF_DATA[3:2]: rd_reg = data_q;
      OFF_ACC[3:2]:  rd_reg = acc_q;
      default:       rd_reg = count_q;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_hit ? rd_reg : '0;
          rresp_d    = rd_hit ? RespOkay : RespSlverr;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ctrl_q     <= '0;
      data_q     <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
`ifdef AXIL_REG_SLAVE_WSTRB_EN
      wstrb_q    <= '0;
`endif
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_have_q  <= aw_have_d;
      w_have_q   <= w_have_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
`ifdef AXIL_REG_SLAVE_WSTRB_EN
      wstrb_q    <= wstrb_d;
`endif
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  logic unused_rd_writable;
  assign unused_rd_writable = rd_writable;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign acc_out       = acc_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave (BASE_ADDR=0).
module tb_axil_reg_slave;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 3;
  localparam int          Bound = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_reg_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) bus ();
  logic [DW-1:0] ctrl_out, acc_out;

  axil_reg_slave #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESP_WIDTH (RW),
    .BASE_ADDR  (0)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus),
    .ctrl_out      (ctrl_out),
    .acc_out       (acc_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] exp_resp, input string tag);
    bit aw_go, w_go;
    int n = 0;
    @(negedge clk);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    while ((bus.awvalid || bus.wvalid) && n < Bound) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      @(negedge clk);
      n++;
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go) bus.wvalid = 1'b0;
    end
    while (!bus.bvalid && n < Bound) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, 32'(n < Bound), 32'd1);
    check_eq({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic [2:0] exp_resp, input string tag);
    int n = 0;
    @(negedge clk);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    while (!bus.arready && n < Bound) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    while (!bus.rvalid && n < Bound) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, 32'(n < Bound), 32'd1);
    check_eq({tag, "_rdata"}, bus.rdata, exp_data);
    check_eq({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_resp));
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state and ready release
    repeat (3) @(negedge clk);
    check_eq("rst_awready_low", 32'(bus.awready), 32'd0);
    check_eq("rst_arready_low", 32'(bus.arready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_awready", 32'(bus.awready), 32'd1);
    check_eq("rel_wready", 32'(bus.wready), 32'd1);
    check_eq("rel_arready", 32'(bus.arready), 32'd1);
    check_eq("rel_bvalid", 32'(bus.bvalid), 32'd0);
    check_eq("rel_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("rel_ctrl_out", ctrl_out, 32'd0);
    axi_read(8'h08, 32'd0, 3'd0, "rst_acc");

    // Accumulation and write counting
    axi_write(8'h00, 32'd1, 4'hF, 3'd0, "wr_ctrl1");
    check_eq("ctrl_out_1", ctrl_out, 32'd1);
    axi_write(8'h04, 32'd5, 4'hF, 3'd0, "wr_data5");
    axi_write(8'h04, 32'd7, 4'hF, 3'd0, "wr_data7");
    axi_read(8'h08, 32'd12, 3'd0, "rd_acc12");
    axi_read(8'h0C, 32'd3, 3'd0, "rd_count3");
    axi_read(8'h04, 32'd7, 3'd0, "rd_data7");
    check_eq("acc_out_12", acc_out, 32'd12);

    // W handshake two cycles ahead of AW, then a stalled response
    @(negedge clk);
    bus.wdata = 32'd3; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check_eq("t3_wready_drop", 32'(bus.wready), 32'd0);
    @(negedge clk);
    check_eq("t3_bvalid_early", 32'(bus.bvalid), 32'd0);
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check_eq("t3_bvalid_lat", 32'(bus.bvalid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_bvalid_hold", 32'(bus.bvalid), 32'd1);
    end
    check_eq("t3_bresp", 32'(bus.bresp), 32'd0);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check_eq("t3_bvalid_clr", 32'(bus.bvalid), 32'd0);
    check_eq("t3_awready", 32'(bus.awready), 32'd1);
    check_eq("t3_wready", 32'(bus.wready), 32'd1);
    axi_read(8'h08, 32'd15, 3'd0, "rd_acc15");

    // Error responses leave state untouched
    axi_write(8'h08, 32'h99, 4'hF, 3'd2, "wr_acc_ro");
    axi_write(8'h05, 32'h99, 4'hF, 3'd2, "wr_unaligned");
    axi_read(8'h0C, 32'd4, 3'd0, "rd_count4");
    axi_read(8'h10, 32'd0, 3'd2, "rd_miss");
    axi_read(8'h08, 32'd15, 3'd0, "rd_acc15b");

    // Self-clearing ACC clear strobe
    axi_write(8'h00, 32'd3, 4'hF, 3'd0, "wr_ctrl_clr");
    axi_read(8'h00, 32'd1, 3'd0, "rd_ctrl1");
    axi_read(8'h08, 32'd0, 3'd0, "rd_acc_clr");

    // Byte lanes (full-word replace when strobes are ignored); ACC wraps mod 2^32
    axi_write(8'h04, 32'hAABBCCDD, 4'hF, 3'd0, "wr_data_full");
    axi_write(8'h04, 32'h11223344, 4'b0101, 3'd0, "wr_data_strb");
`ifdef AXIL_REG_SLAVE_WSTRB_EN
    axi_read(8'h04, 32'hAA22CC44, 3'd0, "rd_data_strb");
    axi_read(8'h08, 32'h54DE9921, 3'd0, "rd_acc_strb");
`else
    axi_read(8'h04, 32'h11223344, 3'd0, "rd_data_strb");
    axi_read(8'h08, 32'hBBDE0021, 3'd0, "rd_acc_strb");
`endif
    axi_read(8'h0C, 32'd7, 3'd0, "rd_count7");

    // Reset while a response is pending
    @(negedge clk);
    bus.awaddr = 8'h00; bus.awvalid = 1'b1; bus.wdata = 32'd5; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_eq("t6_bvalid_pre", 32'(bus.bvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_bvalid_rst", 32'(bus.bvalid), 32'd0);
    check_eq("t6_ctrl_out_rst", ctrl_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_awready", 32'(bus.awready), 32'd1);
    check_eq("t6_bvalid_after", 32'(bus.bvalid), 32'd0);
    axi_read(8'h00, 32'd0, 3'd0, "t6_ctrl");
    axi_read(8'h08, 32'd0, 3'd0, "t6_acc");
    axi_read(8'h0C, 32'd0, 3'd0, "t6_count");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
